// File: rtl/spi_pkg.sv
// Shared types and constants for the SPI slave front end.
package spi_pkg;

   typedef enum logic [2:0] {
      IDLE,
      CHK_CMD,
      WRITE,
      READ_ADD,
      READ_DATA
   } state_e;

   localparam logic [1:0] CMD_WR_ADDR = 2'b00;
   localparam logic [1:0] CMD_WR_DATA = 2'b01;
   localparam logic [1:0] CMD_RD_ADDR = 2'b10;
   localparam logic [1:0] CMD_RD_DATA = 2'b11;

   localparam int DEF_DATA_W = 8;
   localparam int FRAME_W    = DEF_DATA_W + 2;

endpackage

// File: rtl/spi_tx_serializer.sv
// Read-reply shifter: captures a RAM word on load and walks it out MSB-first on MISO.
module spi_tx_serializer #(
   parameter int DATA_W = 8
) (
   input  logic              clk_i,
   input  logic              rst_n_i,
   input  logic              clear_i,
   input  logic              load_i,
   input  logic [DATA_W-1:0] data_i,
   output logic              miso_o,
   output logic              busy_o
);

   localparam int CW = $clog2(DATA_W);

   logic [DATA_W-1:0] data_q, data_d;
   logic [CW-1:0]     cnt_q, cnt_d;
   logic              busy_q, busy_d;
   logic              miso_q, miso_d;

   always_ff @(posedge clk_i) begin
      if (!rst_n_i) begin
         data_q <= '0;
         cnt_q  <= '0;
         busy_q <= 1'b0;
         miso_q <= 1'b0;
      end else begin
         data_q <= data_d;
         cnt_q  <= cnt_d;
         busy_q <= busy_d;
         miso_q <= miso_d;
      end
   end

   // The load edge only captures; the first data bit appears on the following edge.
   always_comb begin
      data_d = data_q;
      cnt_d  = cnt_q;
      busy_d = busy_q;
      miso_d = 1'b0;
      if (clear_i) begin
         busy_d = 1'b0;
         cnt_d  = '0;
      end else if (load_i) begin
         data_d = data_i;
         cnt_d  = CW'(DATA_W - 1);
         busy_d = 1'b1;
      end else if (busy_q) begin
         miso_d = data_q[cnt_q];
         if (cnt_q == '0) begin
            busy_d = 1'b0;
         end else begin
            cnt_d = cnt_q - CW'(1);
         end
      end
   end

   assign miso_o = miso_q;
   assign busy_o = busy_q;

endmodule

// File: rtl/spi_slave_if.sv
// SPI slave front end: deserialises {cmd, payload} frames for the RAM and
// serialises the RAM's read reply back on MISO.
module spi_slave_if
   import spi_pkg::*;
#(
   parameter int DATA_W = DEF_DATA_W
) (
   input  logic              clk_i,
   input  logic              rst_n_i,
   input  logic              SS_n_i,
   input  logic              MOSI_i,
   output logic              MISO_o,
   output logic [DATA_W+1:0] rx_data_o,
   output logic              rx_valid_o,
   input  logic [DATA_W-1:0] tx_data_i,
   input  logic              tx_valid_i
);

   localparam int CNT_W = $clog2(DATA_W + 3);
   localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W + 1);
   localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DATA_W + 2);

   state_e            state_q, state_d;
   logic [DATA_W:0]   shreg_q, shreg_d;
   logic [DATA_W+1:0] rx_data_q, rx_data_d;
   logic              rx_valid_q, rx_valid_d;
   logic [CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
   logic              rd_addr_done_q, rd_addr_done_d;
   logic              tx_armed_q, tx_armed_d;
   logic              tx_load;
   logic              tx_busy;

   always_ff @(posedge clk_i) begin
      if (!rst_n_i) begin
         state_q        <= IDLE;
         shreg_q        <= '0;
         rx_data_q      <= '0;
         rx_valid_q     <= 1'b0;
         bit_cnt_q      <= '0;
         rd_addr_done_q <= 1'b0;
         tx_armed_q     <= 1'b0;
      end else begin
         state_q        <= state_d;
         shreg_q        <= shreg_d;
         rx_data_q      <= rx_data_d;
         rx_valid_q     <= rx_valid_d;
         bit_cnt_q      <= bit_cnt_d;
         rd_addr_done_q <= rd_addr_done_d;
         tx_armed_q     <= tx_armed_d;
      end
   end

   // Once a frame is complete the data states just hold, so extra bits are ignored.
   always_comb begin
      state_d        = state_q;
      shreg_d        = shreg_q;
      rx_data_d      = rx_data_q;
      rx_valid_d     = 1'b0;
      bit_cnt_d      = bit_cnt_q;
      rd_addr_done_d = rd_addr_done_q;
      tx_armed_d     = tx_armed_q;
      tx_load        = 1'b0;
      if (state_q != IDLE && SS_n_i) begin
         state_d    = IDLE;
         bit_cnt_d  = '0;
         tx_armed_d = 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               bit_cnt_d = '0;
               if (!SS_n_i) begin
                  state_d = CHK_CMD;
               end
            end
            CHK_CMD: begin
               shreg_d   = {shreg_q[DATA_W-1:0], MOSI_i};
               bit_cnt_d = CNT_W'(1);
               if (!MOSI_i) begin
                  state_d = WRITE;
               end else if (!rd_addr_done_q) begin
                  state_d = READ_ADD;
               end else begin
                  state_d = READ_DATA;
               end
            end
            default: begin
               if (bit_cnt_q < FULL_CNT) begin
                  shreg_d   = {shreg_q[DATA_W-1:0], MOSI_i};
                  bit_cnt_d = bit_cnt_q + CNT_W'(1);
                  if (bit_cnt_q == LAST_BIT) begin
                     rx_data_d  = {shreg_q, MOSI_i};
                     rx_valid_d = 1'b1;
                     if (state_q == READ_ADD) begin
                        rd_addr_done_d = 1'b1;
                     end
                     if (state_q == READ_DATA) begin
                        rd_addr_done_d = 1'b0;
                        tx_armed_d     = 1'b1;
                     end
                  end
               end else if (state_q == READ_DATA && tx_armed_q && tx_valid_i && !tx_busy) begin
                  tx_load    = 1'b1;
                  tx_armed_d = 1'b0;
               end
            end
         endcase
      end
   end

   spi_tx_serializer #(
      .DATA_W(DATA_W)
   ) u_tx (
      .clk_i  (clk_i),
      .rst_n_i(rst_n_i),
      .clear_i(SS_n_i),
      .load_i (tx_load),
      .data_i (tx_data_i),
      .miso_o (MISO_o),
      .busy_o (tx_busy)
   );

   assign rx_data_o  = rx_data_q;
   assign rx_valid_o = rx_valid_q;

endmodule

// File: tb/tb_spi_slave_if.sv
// Directed self-checking bench for spi_slave_if: write, read pair, abort and reset-mid-reply.
module tb_spi_slave_if;
   import spi_pkg::*;

   logic       clk;
   logic       rst_n;
   logic       ssN;
   logic       mosi;
   logic       miso;
   logic [9:0] rxData;
   logic       rxValid;
   logic [7:0] txData;
   logic       txValid;

   int checks = 0;
   int errors = 0;

   spi_slave_if #(
      .DATA_W(8)
   ) dut (
      .clk_i     (clk),
      .rst_n_i   (rst_n),
      .SS_n_i    (ssN),
      .MOSI_i    (mosi),
      .MISO_o    (miso),
      .rx_data_o (rxData),
      .rx_valid_o(rxValid),
      .tx_data_i (txData),
      .tx_valid_i(txValid)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Inputs are driven and outputs sampled 2 time units after each rising edge.
   task automatic step();
      @(posedge clk);
      #2;
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Starts a frame from IDLE, shifts 10 bits MSB-first, then extraBits more ones.
   task automatic applyStimulus(input logic [9:0] frame, input int extraBits,
                                output int latency, output int pulses,
                                output logic [9:0] captured, output int misoHigh);
      int n;
      latency  = -1;
      pulses   = 0;
      captured = '0;
      misoHigh = 0;
      n        = 0;
      ssN      = 1'b0;
      step();
      for (int i = 9; i >= 0; i--) begin
         mosi = frame[i];
         step();
         n++;
         if (rxValid === 1'b1) begin
            if (pulses == 0) latency = n;
            pulses++;
            captured = rxData;
         end
         if (miso !== 1'b0) misoHigh++;
      end
      for (int i = 0; i < extraBits; i++) begin
         mosi = 1'b1;
         step();
         n++;
         if (rxValid === 1'b1) pulses++;
         if (miso !== 1'b0) misoHigh++;
      end
      mosi = 1'b0;
   endtask

   task automatic endFrame();
      ssN = 1'b1;
      step();
   endtask

   int         lat;
   int         pulses;
   int         misoHigh;
   logic [9:0] cap;
   logic [7:0] replyWord;

   initial begin
      rst_n   = 1'b0;
      ssN     = 1'b0;
      mosi    = 1'b0;
      txData  = 8'h00;
      txValid = 1'b0;

      // 1. reset with SS_n low and MOSI toggling
      step();
      mosi = 1'b1;
      step();
      mosi = 1'b0;
      checkOutput("rst_miso", 32'(miso), 32'd0);
      checkOutput("rst_rxvalid", 32'(rxValid), 32'd0);
      checkOutput("rst_rxdata", 32'(rxData), 32'd0);
      checkOutput("rst_state", 32'(dut.state_q), 32'(IDLE));
      checkOutput("rst_rdaddr", 32'(dut.rd_addr_done_q), 32'd0);
      ssN   = 1'b1;
      rst_n = 1'b1;
      step();
      step();
      checkOutput("idle_state", 32'(dut.state_q), 32'(IDLE));

      // 2. write address, with three surplus bits that must be ignored
      applyStimulus(10'b00_0000_0100, 3, lat, pulses, cap, misoHigh);
      checkOutput("wa_data", 32'(cap), 32'h004);
      checkOutput("wa_latency", 32'(lat), 32'd10);
      checkOutput("wa_pulses", 32'(pulses), 32'd1);
      checkOutput("wa_miso", 32'(misoHigh), 32'd0);
      endFrame();
      checkOutput("wa_idle", 32'(dut.state_q), 32'(IDLE));

      // 3. write data
      applyStimulus(10'b01_0000_0111, 2, lat, pulses, cap, misoHigh);
      checkOutput("wd_data", 32'(cap), 32'h107);
      checkOutput("wd_pulses", 32'(pulses), 32'd1);
      checkOutput("wd_rdaddr", 32'(dut.rd_addr_done_q), 32'd0);
      endFrame();

      // tx_valid while idle must not start a reply
      txData  = 8'hFF;
      txValid = 1'b1;
      step();
      txValid = 1'b0;
      misoHigh = 0;
      for (int i = 0; i < 4; i++) begin
         step();
         if (miso !== 1'b0) misoHigh++;
      end
      checkOutput("idle_txvalid_miso", 32'(misoHigh), 32'd0);

      // 4. read address then read data with reply 8'h07
      applyStimulus(10'b10_0000_0100, 1, lat, pulses, cap, misoHigh);
      checkOutput("ra_data", 32'(cap), 32'h204);
      checkOutput("ra_pulses", 32'(pulses), 32'd1);
      checkOutput("ra_rdaddr", 32'(dut.rd_addr_done_q), 32'd1);
      endFrame();
      applyStimulus(10'b11_0000_0000, 0, lat, pulses, cap, misoHigh);
      checkOutput("rd_data", 32'(cap), 32'h300);
      checkOutput("rd_latency", 32'(lat), 32'd10);
      checkOutput("rd_rdaddr", 32'(dut.rd_addr_done_q), 32'd0);
      replyWord = 8'h07;
      txData    = replyWord;
      txValid   = 1'b1;
      step();
      txValid = 1'b0;
      txData  = 8'h00;
      checkOutput("rd_load_miso", 32'(miso), 32'd0);
      for (int k = 7; k >= 0; k--) begin
         step();
         checkOutput($sformatf("rd_miso_bit%0d", k), 32'(miso), 32'(replyWord[k]));
      end
      step();
      checkOutput("rd_miso_after", 32'(miso), 32'd0);
      endFrame();
      checkOutput("rd_rdaddr_end", 32'(dut.rd_addr_done_q), 32'd0);

      // 5. abort a write frame after 5 bits
      ssN = 1'b0;
      step();
      pulses = 0;
      for (int i = 0; i < 5; i++) begin
         mosi = (i == 2);
         step();
         if (rxValid === 1'b1) pulses++;
      end
      ssN = 1'b1;
      step();
      if (rxValid === 1'b1) pulses++;
      checkOutput("ab_state", 32'(dut.state_q), 32'(IDLE));
      checkOutput("ab_bitcnt", 32'(dut.bit_cnt_q), 32'd0);
      for (int i = 0; i < 6; i++) begin
         step();
         if (rxValid === 1'b1) pulses++;
      end
      checkOutput("ab_pulses", 32'(pulses), 32'd0);
      applyStimulus(10'b01_1010_0101, 0, lat, pulses, cap, misoHigh);
      checkOutput("ab_next_data", 32'(cap), 32'h1A5);
      checkOutput("ab_next_latency", 32'(lat), 32'd10);
      endFrame();

      // 6. reset during the 4th reply bit
      applyStimulus(10'b10_0001_0000, 0, lat, pulses, cap, misoHigh);
      checkOutput("r6_ra_data", 32'(cap), 32'h210);
      endFrame();
      applyStimulus(10'b11_0000_0001, 0, lat, pulses, cap, misoHigh);
      checkOutput("r6_rd_data", 32'(cap), 32'h301);
      txData  = 8'hF0;
      txValid = 1'b1;
      step();
      txValid = 1'b0;
      for (int i = 0; i < 4; i++) step();
      checkOutput("r6_bit4", 32'(miso), 32'd1);
      rst_n = 1'b0;
      step();
      checkOutput("r6_miso", 32'(miso), 32'd0);
      checkOutput("r6_rdaddr", 32'(dut.rd_addr_done_q), 32'd0);
      checkOutput("r6_state", 32'(dut.state_q), 32'(IDLE));
      rst_n = 1'b1;
      ssN   = 1'b1;
      misoHigh = 0;
      for (int i = 0; i < 10; i++) begin
         step();
         if (miso !== 1'b0) misoHigh++;
      end
      checkOutput("r6_quiet", 32'(misoHigh), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
